rv_g_wb_arbiter: RTL and testbench

Writeback arbiter for the RV G register file. Collects results from `NUM_SRC` execution units over valid/ready handshakes, picks one per cycle, and drives the register file's single write-and-unlock port through a registered output stage. It is the writer that releases destination-register locks taken at issue time, so it must never drop or duplicate an accepted result.

---
 rtl/rv_g_wb_arbiter_if.sv | 27 ++
 rtl/rv_g_wb_arbiter.sv | 95 +++++++++
 tb/tb_rv_g_wb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_g_wb_arbiter_if.sv
// Writeback arbiter bus: NUM_SRC result handshakes in, one register-file write-and-unlock port out.
// The slave modport is the arbiter's view; master is the producer/consumer environment.
interface rv_g_wb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 64,
    parameter int FLEN    = 32
);
    localparam int MaxLen = (FLEN > XLEN) ? FLEN : XLEN;

    logic [NUM_SRC-1:0]             src_valid_i;
    logic [NUM_SRC-1:0][5:0]        src_addr_i;
    logic [NUM_SRC-1:0][MaxLen-1:0] src_data_i;
    logic [NUM_SRC-1:0]             src_ready_o;
    logic [5:0]                     wr_addr_o;
    logic [MaxLen-1:0]              wr_data_o;
    logic                           wr_en_o;

    modport master (
        output src_valid_i, src_addr_i, src_data_i,
        input  src_ready_o, wr_addr_o, wr_data_o, wr_en_o
    );

    modport slave (
        input  src_valid_i, src_addr_i, src_data_i,
        output src_ready_o, wr_addr_o, wr_data_o, wr_en_o
    );
endinterface

// File: rtl/rv_g_wb_arbiter.sv
// Writeback arbiter: one grant per cycle into a registered write-and-unlock stage.
// Define RV_G_WB_ARBITER_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module rv_g_wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 64,
    parameter int FLEN    = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    rv_g_wb_arbiter_if.slave     bus
);
    localparam int MaxLen = (FLEN > XLEN) ? FLEN : XLEN;
    localparam int IDX_W  = $clog2(NUM_SRC);

    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic [NUM_SRC-1:0] w_ready;
    logic [5:0]         w_sel_addr;
    logic [MaxLen-1:0]  w_sel_data;

    logic               r_wr_en;
    logic [5:0]         r_wr_addr;
    logic [MaxLen-1:0]  r_wr_data;

`ifdef RV_G_WB_ARBITER_RR_EN
    logic [IDX_W-1:0]   r_ptr;

    // Modulo add so non-power-of-two source counts wrap back to 0.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IDX_W'(sum % NUM_SRC);
    endfunction
`endif

    // Scan sources in priority order; the first valid one seen is the grant.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef RV_G_WB_ARBITER_RR_EN
            w_cand = wrap_add(r_ptr, k);
`else
            w_cand = IDX_W'(k);
`endif
            w_gnt_idx = (!w_gnt_vld && bus.src_valid_i[w_cand]) ? w_cand : w_gnt_idx;
            w_gnt_vld = w_gnt_vld | bus.src_valid_i[w_cand];
        end
    end

    // One-hot ready for the granted source only.
    always_comb begin
        w_ready            = '0;
        w_ready[w_gnt_idx] = w_gnt_vld;
    end

    assign w_sel_addr      = bus.src_addr_i[w_gnt_idx];
    assign w_sel_data      = bus.src_data_i[w_gnt_idx];
    assign bus.src_ready_o = w_ready;

    // Output stage: x0 results are consumed without a write; address/data hold when idle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 6'd0;
            r_wr_data <= '0;
        end else if (w_gnt_vld) begin
            r_wr_en   <= (w_sel_addr != 6'd0);
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

`ifdef RV_G_WB_ARBITER_RR_EN
    // Search pointer moves one past the last winner.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_ptr <= wrap_add(w_gnt_idx, 32'd1);
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign bus.wr_en_o   = r_wr_en;
    assign bus.wr_addr_o = r_wr_addr;
    assign bus.wr_data_o = r_wr_data;
endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
// Bench for rv_g_wb_arbiter: directed scenarios then randomized traffic against a queue-free
// behavioural model (grant = first valid in search order, output = registered copy of the winner).
module tb_rv_g_wb_arbiter;
    localparam int NS = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [5:0]  t_addr [NS];
    logic [63:0] t_data [NS];

    int          m_ptr;
    logic        m_en;
    logic [5:0]  m_addr;
    logic [63:0] m_data;
    int          last_g;

    rv_g_wb_arbiter_if #(.NUM_SRC(NS), .XLEN(64), .FLEN(32)) bus ();

    rv_g_wb_arbiter #(.NUM_SRC(NS), .XLEN(64), .FLEN(32)) dut (
        .clk_i   (clk),
        .arst_ni (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NS-1:0] v, input int p);
        int idx;
`ifdef RV_G_WB_ARBITER_RR_EN
        for (int k = 0; k < NS; k++) begin
            idx = (p + k) % NS;
            if (v[idx]) return idx;
        end
`else
        for (int k = 0; k < NS; k++) begin
            idx = k + 0 * p;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // One clock: drive, check ready mid-cycle, advance the model, check registered outputs.
    task automatic step(input logic [NS-1:0] v);
        int g;
        logic [NS-1:0] exp_ready;
        bus.src_valid_i = v;
        for (int i = 0; i < NS; i++) begin
            bus.src_addr_i[i] = t_addr[i];
            bus.src_data_i[i] = t_data[i];
        end
        @(negedge clk);
        g = model_grant(v, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g[1:0]] = 1'b1;
        chk("ready", 64'(bus.src_ready_o), 64'(exp_ready));
        last_g = g;
        if (g >= 0) begin
            m_en   = (t_addr[g] != 6'd0);
            m_addr = t_addr[g];
            m_data = t_data[g];
            m_ptr  = (g + 1) % NS;
        end else begin
            m_en = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("wr_en",   64'(bus.wr_en_o),   64'(m_en));
        chk("wr_addr", 64'(bus.wr_addr_o), 64'(m_addr));
        chk("wr_data", bus.wr_data_o,      m_data);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = 6'd0;
        m_data = 64'd0;
    endtask

    initial begin
        logic [NS-1:0] pend;
        int            age [NS];
        int            r;
        checks = 0;
        errors = 0;
        last_g = -1;
        model_reset();
        for (int i = 0; i < NS; i++) begin
            t_addr[i] = 6'd0;
            t_data[i] = 64'd0;
            bus.src_addr_i[i] = 6'd0;
            bus.src_data_i[i] = 64'd0;
        end
        bus.src_valid_i = '0;

        // Reset with all valids low
        rst_n = 1'b0;
        #12;
        chk("rst_wr_en",   64'(bus.wr_en_o),     64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr_o),   64'd0);
        chk("rst_wr_data", bus.wr_data_o,        64'd0);
        chk("rst_ready",   64'(bus.src_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b0000);
        step(4'b0000);

        // Single source
        t_addr[1] = 6'h05;
        t_data[1] = 64'hDEAD_BEEF;
        step(4'b0010);
        chk("single_wr_en",   64'(bus.wr_en_o),   64'd1);
        chk("single_wr_data", bus.wr_data_o,      64'hDEAD_BEEF);
        step(4'b0000);
        chk("single_idle",    64'(bus.wr_en_o),   64'd0);

        // All four continuously valid, starting from a fresh reset
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            t_addr[i] = 6'(6'h21 + i);
            t_data[i] = 64'(64'h100 + i);
        end
        for (int c = 0; c < 5; c++) begin
            step(4'b1111);
`ifdef RV_G_WB_ARBITER_RR_EN
            chk("rr_order", 64'(last_g), 64'(c % NS));
`else
            chk("fixed_order", 64'(last_g), 64'd0);
`endif
            chk("all_valid_en", 64'(bus.wr_en_o), 64'd1);
        end

        // x0 drop, then observe the pointer through the next grant
        t_addr[2] = 6'h00;
        t_data[2] = 64'hBAD0;
        step(4'b0100);
        chk("x0_no_write", 64'(bus.wr_en_o), 64'd0);
        t_addr[2] = 6'h23;
        step(4'b1111);

        // Same-address pair, written in grant order
        t_addr[0] = 6'h0A; t_data[0] = 64'd1;
        t_addr[3] = 6'h0A; t_data[3] = 64'd2;
        step(4'b1001);
        chk("pair_first", bus.wr_data_o, 64'd1);
        step(4'b1000);
        chk("pair_second", bus.wr_data_o, 64'd2);
        chk("pair_second_en", 64'(bus.wr_en_o), 64'd1);

        // Mid-stream reset while a write is in flight
        step(4'b1111);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_wr_en",   64'(bus.wr_en_o),   64'd0);
        chk("midrst_wr_addr", 64'(bus.wr_addr_o), 64'd0);
        bus.src_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1111);
        chk("midrst_first_grant", 64'(last_g), 64'd0);

        // Randomized traffic: each source holds its result until accepted
        pend = '0;
        for (int i = 0; i < NS; i++) age[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    r = $urandom_range(0, 7);
                    t_addr[i] = (r == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                    t_data[i] = {$urandom, $urandom};
                    pend[i]   = 1'b1;
                end
            end
            step(pend);
            for (int i = 0; i < NS; i++) begin
                if (pend[i]) age[i]++;
            end
            if (last_g >= 0) begin
`ifdef RV_G_WB_ARBITER_RR_EN
                chk("starvation_bound", 64'(age[last_g] <= NS), 64'd1);
`endif
                age[last_g]  = 0;
                pend[last_g] = 1'b0;
            end
        end
        step(4'b0000);
        step(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
